mc_port_arbiter: RTL and testbench

//  Sequences a single-port BRAM shared by LOAD_COUNT load ports and STORE_COUNT store ports.

---
 rtl/mc_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mc_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_port_arbiter.sv
// mc_port_arbiter: round-robin sequencer for one single-port BRAM shared by
// LOAD_COUNT load ports and STORE_COUNT store ports. Load data returns to the
// issuing port one cycle after the BRAM read. Declared stores are counted down
// so that an elastic "memory empty" token can be raised for end_node.
module mc_port_arbiter #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int LOAD_COUNT   = 2,
    parameter int STORE_COUNT  = 2,
    parameter int CNT_SIZE     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LOAD_COUNT*ADDRESS_SIZE-1:0] ld_addr_bits,
    input  logic [LOAD_COUNT-1:0]             ld_addr_valid,
    output logic [LOAD_COUNT-1:0]             ld_addr_ready,
    output logic [LOAD_COUNT*DATA_SIZE-1:0]   ld_data_bits,
    output logic [LOAD_COUNT-1:0]             ld_data_valid,
    input  logic [LOAD_COUNT-1:0]             ld_data_ready,
    input  logic [STORE_COUNT*ADDRESS_SIZE-1:0] st_addr_bits,
    input  logic [STORE_COUNT-1:0]            st_addr_valid,
    output logic [STORE_COUNT-1:0]            st_addr_ready,
    input  logic [STORE_COUNT*DATA_SIZE-1:0]  st_data_bits,
    input  logic [STORE_COUNT-1:0]            st_data_valid,
    output logic [STORE_COUNT-1:0]            st_data_ready,
    input  logic [CNT_SIZE-1:0]               bb_st_count,
    input  logic                              bb_valid,
    output logic                              bb_ready,
    output logic [ADDRESS_SIZE-1:0]           mem_addr,
    output logic                              mem_ce,
    output logic                              mem_we,
    output logic [DATA_SIZE-1:0]              mem_dout,
    input  logic [DATA_SIZE-1:0]              mem_din,
    output logic                              empty_valid,
    input  logic                              empty_ready
);

    localparam int unsigned N  = LOAD_COUNT + STORE_COUNT;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (LOAD_COUNT > 1) ? $clog2(LOAD_COUNT) : 1;

    logic [PW-1:0]        ptr;
    logic [N-1:0]         elig;
    logic                 grantValid;
    logic [PW-1:0]        grantIdx;
    logic                 storeGrant;
    logic                 loadGrant;
    logic                 inFlight;
    logic [IW-1:0]        inFlightPort;
    logic [DATA_SIZE-1:0] retData [LOAD_COUNT];
    logic [LOAD_COUNT-1:0] retValid;
    logic [CNT_SIZE-1:0]  pending;
    logic [CNT_SIZE-1:0]  pendingNext;
    logic [CNT_SIZE:0]    bbSum;
    logic                 bbFire;
    logic                 bbSeen;
    logic                 emptyFire;

    // Requester eligibility; nothing is eligible while reset is asserted
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < LOAD_COUNT; i++) begin
            elig[i] = ld_addr_valid[i]
                    && !(inFlight && (inFlightPort == IW'(i)))
                    && (!retValid[i] || ld_data_ready[i]);
        end
        for (int unsigned j = 0; j < STORE_COUNT; j++) begin
            elig[LOAD_COUNT + j] = st_addr_valid[j] && st_data_valid[j];
        end
        if (rst) begin
            elig = '0;
        end
    end

    // Round-robin pick: first eligible index at or after ptr, wrapping
    always_comb begin
        int unsigned cand;
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {{(32-PW){1'b0}}, ptr} + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!grantValid && elig[cand]) begin
                grantValid = 1'b1;
                grantIdx   = PW'(cand);
            end
        end
    end

    assign storeGrant = grantValid && (grantIdx >= PW'(LOAD_COUNT));
    assign loadGrant  = grantValid && !storeGrant;
    assign mem_ce     = grantValid;
    assign mem_we     = storeGrant;

    // Steer handshakes and BRAM address/data from the granted port
    always_comb begin
        ld_addr_ready = '0;
        st_addr_ready = '0;
        mem_addr      = '0;
        mem_dout      = '0;
        for (int unsigned i = 0; i < LOAD_COUNT; i++) begin
            if (grantValid && (grantIdx == PW'(i))) begin
                ld_addr_ready[i] = 1'b1;
                mem_addr         = ld_addr_bits[i*ADDRESS_SIZE +: ADDRESS_SIZE];
            end
        end
        for (int unsigned j = 0; j < STORE_COUNT; j++) begin
            if (grantValid && (grantIdx == PW'(LOAD_COUNT + j))) begin
                st_addr_ready[j] = 1'b1;
                mem_addr         = st_addr_bits[j*ADDRESS_SIZE +: ADDRESS_SIZE];
                mem_dout         = st_data_bits[j*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign st_data_ready = st_addr_ready;

    // Advance the round-robin pointer and remember which load is reading
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            inFlight     <= 1'b0;
            inFlightPort <= '0;
        end else begin
            if (grantValid) begin
                ptr <= (grantIdx == PW'(N - 1)) ? '0 : grantIdx + PW'(1);
            end
            inFlight <= loadGrant;
            if (loadGrant) begin
                inFlightPort <= IW'(grantIdx);
            end
        end
    end

    // Capture BRAM read data into the issuing port's return register
    always_ff @(posedge clk) begin
        if (rst) begin
            retValid <= '0;
            for (int unsigned i = 0; i < LOAD_COUNT; i++) begin
                retData[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LOAD_COUNT; i++) begin
                if (inFlight && (inFlightPort == IW'(i))) begin
                    retValid[i] <= 1'b1;
                    retData[i]  <= mem_din;
                end else if (retValid[i] && ld_data_ready[i]) begin
                    retValid[i] <= 1'b0;
                end
            end
        end
    end

    // Flatten return registers onto the per-port data bus
    always_comb begin
        ld_data_bits = '0;
        for (int unsigned i = 0; i < LOAD_COUNT; i++) begin
            ld_data_bits[i*DATA_SIZE +: DATA_SIZE] = retData[i];
        end
    end

    assign ld_data_valid = retValid;

    // The count token is refused whenever adding it would overflow the counter
    assign bbSum     = {1'b0, pending} + {1'b0, bb_st_count};
    assign bb_ready  = !bbSum[CNT_SIZE];
    assign bbFire    = bb_valid && bb_ready;
    assign emptyFire = empty_valid && empty_ready;

    // Next pending-store count: add declared stores, then retire one store, never below 0
    always_comb begin
        logic [CNT_SIZE-1:0] added;
        added       = bbFire ? bbSum[CNT_SIZE-1:0] : pending;
        pendingNext = added;
        if (storeGrant && (added != '0)) begin
            pendingNext = added - CNT_SIZE'(1);
        end
    end

    // Pending-store counter and basic-block-seen flag for the empty token
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            bbSeen  <= 1'b0;
        end else begin
            pending <= pendingNext;
            if (bbFire) begin
                bbSeen <= 1'b1;
            end else if (emptyFire) begin
                bbSeen <= 1'b0;
            end
        end
    end

    assign empty_valid = !rst && bbSeen && (pending == '0) && !inFlight
                       && (retValid == '0) && !bb_valid;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Bench for mc_port_arbiter with two load and two store ports, a behavioural
// 1-cycle-latency BRAM, and a per-port scoreboard for load return data.
module tb_mc_port_arbiter;

    localparam int DS = 32;
    localparam int AS = 32;
    localparam int L  = 2;
    localparam int S  = 2;
    localparam int CS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [L*AS-1:0] ldAddrBits;
    logic [L-1:0]    ldAddrValid;
    logic [L-1:0]    ldAddrReady;
    logic [L*DS-1:0] ldDataBits;
    logic [L-1:0]    ldDataValid;
    logic [L-1:0]    ldDataReady;
    logic [S*AS-1:0] stAddrBits;
    logic [S-1:0]    stAddrValid;
    logic [S-1:0]    stAddrReady;
    logic [S*DS-1:0] stDataBits;
    logic [S-1:0]    stDataValid;
    logic [S-1:0]    stDataReady;
    logic [CS-1:0]   bbStCount;
    logic            bbValid;
    logic            bbReady;
    logic [AS-1:0]   memAddr;
    logic            memCe;
    logic            memWe;
    logic [DS-1:0]   memDout;
    logic [DS-1:0]   memDin;
    logic            emptyValid;
    logic            emptyReady;

    mc_port_arbiter #(
        .DATA_SIZE    (DS),
        .ADDRESS_SIZE (AS),
        .LOAD_COUNT   (L),
        .STORE_COUNT  (S),
        .CNT_SIZE     (CS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_addr_bits  (ldAddrBits),
        .ld_addr_valid (ldAddrValid),
        .ld_addr_ready (ldAddrReady),
        .ld_data_bits  (ldDataBits),
        .ld_data_valid (ldDataValid),
        .ld_data_ready (ldDataReady),
        .st_addr_bits  (stAddrBits),
        .st_addr_valid (stAddrValid),
        .st_addr_ready (stAddrReady),
        .st_data_bits  (stDataBits),
        .st_data_valid (stDataValid),
        .st_data_ready (stDataReady),
        .bb_st_count   (bbStCount),
        .bb_valid      (bbValid),
        .bb_ready      (bbReady),
        .mem_addr      (memAddr),
        .mem_ce        (memCe),
        .mem_we        (memWe),
        .mem_dout      (memDout),
        .mem_din       (memDin),
        .empty_valid   (emptyValid),
        .empty_ready   (emptyReady)
    );

    function automatic logic [31:0] initWord(input logic [7:0] a);
        return (a == 8'h04) ? 32'h0000_CAFE : {24'hA5A5A5, a};
    endfunction

    // Behavioural BRAM: unwritten words read back their initial pattern
    logic [31:0]  bram [256];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (memCe) begin
            if (memWe) begin
                bram[memAddr[7:0]]    <= memDout;
                written[memAddr[7:0]] <= 1'b1;
            end else begin
                memDin <= written[memAddr[7:0]] ? bram[memAddr[7:0]] : initWord(memAddr[7:0]);
            end
        end
    end

    logic [31:0] expMem [256];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard at the sample point, then advance one clock
    task automatic tick();
        logic [31:0] e;
        #1;
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                if (ldAddrValid[i] && ldAddrReady[i]) begin
                    e = expMem[ldAddrBits[i*AS +: 8]];
                    if (i == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (ldDataValid[i] && ldDataReady[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_ld%0d_unexpected: got data 0x%0h expected no return", i, ldDataBits[i*DS +: DS]);
                    end else begin
                        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                        check($sformatf("sb_ld%0d_data", i), ldDataBits[i*DS +: DS], e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ldAddrValid = '0;
        stAddrValid = '0;
        stDataValid = '0;
        bbValid     = 1'b0;
        emptyReady  = 1'b0;
        ldDataReady = 2'b11;
        bbStCount   = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic setStores(input logic [1:0] v);
        stAddrValid = v;
        stDataValid = v;
    endtask

    typedef struct {
        logic [1:0]  ldV;
        logic [1:0]  stV;
        logic [3:0]  grant;
        logic [31:0] addr;
        logic        we;
    } vec_t;
    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'b11, 2'b11, 4'b0001, 32'h10, 1'b0};
        tbl[1]  = '{2'b11, 2'b11, 4'b0010, 32'h11, 1'b0};
        tbl[2]  = '{2'b11, 2'b11, 4'b0100, 32'hF0, 1'b1};
        tbl[3]  = '{2'b11, 2'b11, 4'b1000, 32'hF1, 1'b1};
        tbl[4]  = '{2'b00, 2'b01, 4'b0100, 32'hF0, 1'b1};
        tbl[5]  = '{2'b10, 2'b01, 4'b0010, 32'h11, 1'b0};
        tbl[6]  = '{2'b10, 2'b00, 4'b0000, 32'h00, 1'b0};
        tbl[7]  = '{2'b01, 2'b10, 4'b1000, 32'hF1, 1'b1};
        tbl[8]  = '{2'b11, 2'b00, 4'b0001, 32'h10, 1'b0};
        tbl[9]  = '{2'b00, 2'b10, 4'b1000, 32'hF1, 1'b1};
        tbl[10] = '{2'b00, 2'b00, 4'b0000, 32'h00, 1'b0};
        tbl[11] = '{2'b01, 2'b11, 4'b0001, 32'h10, 1'b0};

        for (int i = 0; i < 256; i++) expMem[i] = initWord(8'(i));
        ldAddrBits = '0;
        stAddrBits = '0;
        stDataBits = '0;
        doReset();

        // Reset state
        #1;
        check("rst_mem_ce", memCe, 0);
        check("rst_mem_we", memWe, 0);
        check("rst_bb_ready", bbReady, 1);
        check("rst_empty_valid", emptyValid, 0);
        check("rst_ld_data_valid", ldDataValid, 0);

        // Single load: data returns two cycles after the grant
        ldAddrBits[31:0] = 32'h4;
        ldAddrValid      = 2'b01;
        #1;
        check("t1_grant", {stAddrReady, ldAddrReady}, 4'b0001);
        check("t1_mem_addr", memAddr, 32'h4);
        check("t1_mem_we", memWe, 0);
        tick();
        ldAddrValid = '0;
        #1;
        check("t1_valid_t1", ldDataValid, 2'b00);
        tick();
        check("t1_valid_t2", ldDataValid, 2'b01);
        check("t1_data_t2", ldDataBits[31:0], 32'h0000_CAFE);
        tick();
        tick();

        // Table-driven round-robin vectors
        doReset();
        ldAddrBits = {32'h11, 32'h10};
        stAddrBits = {32'hF1, 32'hF0};
        stDataBits = {32'h101, 32'h100};
        for (int r = 0; r < 12; r++) begin
            ldAddrValid = tbl[r].ldV;
            setStores(tbl[r].stV);
            #1;
            check($sformatf("tbl%0d_grant", r), {stDataReady, stAddrReady, ldAddrReady},
                  {tbl[r].grant[3:2], tbl[r].grant});
            check($sformatf("tbl%0d_ce", r), memCe, |tbl[r].grant);
            check($sformatf("tbl%0d_we", r), memWe, tbl[r].we);
            check($sformatf("tbl%0d_addr", r), memAddr, tbl[r].addr);
            tick();
        end
        idle();
        tick();
        tick();
        tick();

        // Store accounting and empty token
        doReset();
        bbStCount = 8'd2;
        bbValid   = 1'b1;
        #1;
        check("t3_bb_ready", bbReady, 1);
        check("t3_empty_bbvalid", emptyValid, 0);
        tick();
        bbValid = 1'b0;
        stAddrBits[31:0] = 32'h8;
        stDataBits[31:0] = 32'h5;
        setStores(2'b01);
        #1;
        check("t3_st1_grant", {stAddrReady, ldAddrReady}, 4'b0100);
        check("t3_st1_addr", memAddr, 32'h8);
        check("t3_st1_dout", memDout, 32'h5);
        check("t3_st1_we", memWe, 1);
        check("t3_empty_p2", emptyValid, 0);
        tick();
        stAddrBits[63:32] = 32'h9;
        stDataBits[63:32] = 32'h6;
        setStores(2'b10);
        #1;
        check("t3_st2_addr", memAddr, 32'h9);
        check("t3_st2_dout", memDout, 32'h6);
        check("t3_empty_p1", emptyValid, 0);
        tick();
        setStores(2'b00);
        expMem[8] = 32'h5;
        expMem[9] = 32'h6;
        #1;
        check("t3_empty_after", emptyValid, 1);
        emptyReady = 1'b1;
        tick();
        emptyReady = 1'b0;
        #1;
        check("t3_empty_cleared", emptyValid, 0);
        ldAddrBits  = {32'h9, 32'h8};
        ldAddrValid = 2'b11;
        tick();
        tick();
        ldAddrValid = '0;
        tick();
        tick();
        tick();

        // Simultaneous add and retire; retire at zero saturates
        doReset();
        bbStCount = 8'd1;
        bbValid   = 1'b1;
        tick();
        bbStCount = 8'd3;
        stAddrBits[31:0] = 32'hF2;
        stDataBits[31:0] = 32'h7;
        setStores(2'b01);
        #1;
        check("t4_both_grant", stAddrReady, 2'b01);
        check("t4_both_bbready", bbReady, 1);
        tick();
        idle();
        bbStCount = 8'd253;
        #1;
        check("t4_p3_plus253", bbReady, 0);
        bbStCount = 8'd252;
        #1;
        check("t4_p3_plus252", bbReady, 1);
        doReset();
        setStores(2'b01);
        #1;
        check("t4_sat_grant", stAddrReady, 2'b01);
        tick();
        idle();
        bbStCount = 8'd255;
        #1;
        check("t4_sat_nowrap", bbReady, 1);
        check("t4_sat_empty", emptyValid, 0);
        bbValid = 1'b1;
        tick();
        bbValid   = 1'b0;
        bbStCount = 8'd1;
        #1;
        check("t4_full_plus1", bbReady, 0);

        // Held load return blocks its port only
        doReset();
        ldAddrBits  = {32'h21, 32'h20};
        stAddrBits[31:0] = 32'hF3;
        stDataBits[31:0] = 32'h9;
        ldDataReady = 2'b10;
        ldAddrValid = 2'b01;
        #1;
        check("t5_g0", {stAddrReady, ldAddrReady}, 4'b0001);
        tick();
        #1;
        check("t5_inflight", {stAddrReady, ldAddrReady}, 4'b0000);
        tick();
        ldAddrValid = 2'b11;
        setStores(2'b01);
        #1;
        check("t5_held_valid", ldDataValid[0], 1);
        check("t5_c2_grant", {stAddrReady, ldAddrReady}, 4'b0010);
        tick();
        #1;
        check("t5_c3_grant", {stAddrReady, ldAddrReady}, 4'b0100);
        tick();
        #1;
        check("t5_c4_grant", {stAddrReady, ldAddrReady}, 4'b0010);
        tick();
        setStores(2'b00);
        ldAddrValid = 2'b01;
        ldDataReady = 2'b11;
        #1;
        check("t5_release_grant", {stAddrReady, ldAddrReady}, 4'b0001);
        tick();
        idle();
        tick();
        tick();
        tick();

        // Reset the cycle after a load grant discards the read
        doReset();
        ldAddrBits[31:0] = 32'h30;
        ldAddrValid = 2'b01;
        #1;
        check("t6_grant", ldAddrReady, 2'b01);
        tick();
        rst = 1'b1;
        ldAddrValid = '0;
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("t6_ld_valid", ldDataValid, 0);
        check("t6_mem_ce", memCe, 0);
        check("t6_mem_we", memWe, 0);
        check("t6_bb_ready", bbReady, 1);
        check("t6_empty", emptyValid, 0);
        tick();
        check("t6_ld_valid_late", ldDataValid, 0);
        tick();
        check("t6_ld_valid_later", ldDataValid, 0);

        check("sb_drained", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
